// File: rtl/seq_divider_16x8_pkg.sv
// Shared types and default sizes for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    localparam int N_WIDTH_DEF   = 16;
    localparam int D_WIDTH_DEF   = 8;
    localparam int CNT_WIDTH_DEF = $clog2(N_WIDTH_DEF + 1);

endpackage

// File: rtl/seq_divider_16x8_if.sv
// Operand/result handshake bundle between a producer/consumer and the divider.
interface seq_divider_16x8_if #(
    parameter int N_WIDTH = 16,
    parameter int D_WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [N_WIDTH-1:0] dividend;
    logic [D_WIDTH-1:0] divisor;
    logic               out_valid;
    logic               out_ready;
    logic [N_WIDTH-1:0] quotient;
    logic [D_WIDTH-1:0] remainder;
    logic               div_by_zero;
    logic               busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/seq_divider_16x8_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int D_WIDTH = 8
) (
    input  logic [D_WIDTH-1:0] i_r_in,
    input  logic               i_q_msb,
    input  logic [D_WIDTH-1:0] i_d,
    output logic [D_WIDTH-1:0] o_r_out,
    output logic               o_q_bit
);
    logic [D_WIDTH:0] w_r_shift;
    logic [D_WIDTH:0] w_trial;

    assign w_r_shift = {i_r_in, i_q_msb};
    assign w_trial   = w_r_shift - {1'b0, i_d};
    assign o_q_bit   = ~w_trial[D_WIDTH];
    // A restored remainder is always below the divisor, so D_WIDTH bits hold it.
    assign o_r_out   = o_q_bit ? w_trial[D_WIDTH-1:0] : w_r_shift[D_WIDTH-1:0];
endmodule

// File: rtl/seq_divider_16x8.sv
// Sequential radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// CALC  | stepping the quotient (or one hold cycle for divide-by-zero)
// DONE  | result presented, out_valid=1 until out_ready
module seq_divider_16x8
    import div_pkg::*;
#(
    parameter int N_WIDTH = N_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_divider_16x8_if.slave  bus
);
    localparam int CNT_W = $clog2(N_WIDTH + 1);

    div_state_t         r_state;
    div_state_t         w_next;
    logic [N_WIDTH-1:0] r_q;
    logic [D_WIDTH-1:0] r_r;
    logic [D_WIDTH-1:0] r_d;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dbz;
    logic               w_accept;
    logic               w_step;
    logic [D_WIDTH-1:0] w_r_next;
    logic               w_q_bit;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_step   = (r_state == CALC) && !r_dbz;

    div_step #(.D_WIDTH(D_WIDTH)) u_step (
        .i_r_in  (r_r),
        .i_q_msb (r_q[N_WIDTH-1]),
        .i_d     (r_d),
        .o_r_out (w_r_next),
        .o_q_bit (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = CALC;
            CALC:    if (r_cnt == CNT_W'(1)) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
        bus.busy      = (r_state != IDLE);
    end

    // Divide-by-zero loads its fixed result and spends a single non-stepping CALC
    // cycle, so out_valid rises one edge after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_r   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_d <= bus.divisor;
            r_r <= '0;
            if (bus.divisor == '0) begin
                r_q   <= '1;
                r_cnt <= CNT_W'(1);
                r_dbz <= 1'b1;
            end else begin
                r_q   <= bus.dividend;
                r_cnt <= CNT_W'(N_WIDTH);
                r_dbz <= 1'b0;
            end
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt - 1'b1;
            if (w_step) begin
                r_r <= w_r_next;
                r_q <= {r_q[N_WIDTH-2:0], w_q_bit};
            end
        end
    end

    assign bus.quotient    = r_q;
    assign bus.remainder   = r_r;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider_16x8.sv
// Directed-vector and randomised self-checking bench for seq_divider_16x8.
module tb_seq_divider_16x8;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_divider_16x8_if #(.N_WIDTH(16), .D_WIDTH(8)) bus ();

    seq_divider_16x8 #(.N_WIDTH(16), .D_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] exp_q;
        logic [7:0]  exp_r;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_ovalid_after_consume"}, bus.out_valid, 0);
        chk({tag, "_iready_after_consume"}, bus.in_ready, 1);
    endtask

    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                          input int elat, input int stall, input string tag);
        int cyc;
        cyc = 0;
        while (!bus.in_ready && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_iready_before"}, bus.in_ready, 1);
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_iready_busy"}, bus.in_ready, 0);
        wait_valid(cyc);
        chk({tag, "_latency"}, cyc, elat);
        chk({tag, "_quotient"}, bus.quotient, eq);
        chk({tag, "_remainder"}, bus.remainder, er);
        chk({tag, "_dbz"}, bus.div_by_zero, edbz);
        for (int k = 0; k < stall; k++) begin
            tick();
            chk({tag, "_hold_valid"}, bus.out_valid, 1);
            chk({tag, "_hold_quotient"}, bus.quotient, eq);
            chk({tag, "_hold_remainder"}, bus.remainder, er);
        end
        consume(tag);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [7:0]  a, b;
        logic [15:0] dvd;
        checks = 0;
        errors = 0;

        vecs[0]  = '{16'hFE01, 8'hFF, 16'h00FF, 8'h00, 1'b0, 16};
        vecs[1]  = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16};
        vecs[2]  = '{16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0, 16};
        vecs[3]  = '{16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 16};
        vecs[4]  = '{16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1, 1};
        vecs[5]  = '{16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 16};
        vecs[6]  = '{16'h00FF, 8'hFF, 16'h0001, 8'h00, 1'b0, 16};
        vecs[7]  = '{16'h00FE, 8'hFF, 16'h0000, 8'hFE, 1'b0, 16};
        vecs[8]  = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16};
        vecs[9]  = '{16'hFFFF, 8'h02, 16'h7FFF, 8'h01, 1'b0, 16};
        vecs[10] = '{16'hABCD, 8'h10, 16'h0ABC, 8'h0D, 1'b0, 16};
        vecs[11] = '{16'h0000, 8'h00, 16'hFFFF, 8'h00, 1'b1, 1};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dbz,
                   vecs[i].exp_lat, i % 3, $sformatf("vec%0d", i));
        end

        // Long stall with a competing request that must wait for in_ready.
        bus.dividend = 16'h03E8;
        bus.divisor  = 8'h07;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(cyc);
        chk("hold_latency", cyc, 16);
        bus.dividend = 16'h0064;
        bus.divisor  = 8'h0A;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_quotient", bus.quotient, 16'h008E);
            chk("hold_remainder", bus.remainder, 8'h06);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("release_out_valid", bus.out_valid, 0);
        chk("release_not_accepted", bus.busy, 0);
        chk("release_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("second_accepted", bus.busy, 1);
        wait_valid(cyc);
        chk("second_latency", cyc, 16);
        chk("second_quotient", bus.quotient, 16'h000A);
        chk("second_remainder", bus.remainder, 8'h00);
        consume("second");

        // Asynchronous reset in the middle of a calculation.
        bus.dividend = 16'h5555;
        bus.divisor  = 8'h03;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (8) tick();
        chk("midcalc_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_quotient", bus.quotient, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_no_result", bus.out_valid, 0);
        run_op(16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 16, 1, "postrst");

        // Products divided by one factor recover the other; then arbitrary dividends.
        for (int n = 0; n < 2500; n++) begin
            b = 8'($urandom_range(1, 255));
            if (n < 1500) begin
                a   = 8'($urandom_range(0, 255));
                dvd = 16'(a) * 16'(b);
                run_op(dvd, b, 16'(a), 8'h00, 1'b0, 16, $urandom_range(0, 3), "prod");
            end else begin
                dvd = 16'($urandom_range(0, 65535));
                run_op(dvd, b, dvd / 16'(b), 8'(dvd % 16'(b)), 1'b0, 16,
                       $urandom_range(0, 3), "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
